ibex_rf_write_arbiter: RTL and testbench

IBEX_RF_WRITE_ARBITER -- requirements
Module: ibex_rf_write_arbiter

---
 rtl/ibex_rf_write_arbiter.sv | 96 +++++++++
 tb/tb_ibex_rf_write_arbiter.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/ibex_rf_write_arbiter.sv
// ibex_rf_write_arbiter: arbitrates two writeback requesters onto one register-file write port.
//
// Ports:
//   clk_int, rst_ni          clock, asynchronous active-low reset
//   a_valid_i/a_ready_o      requester A (EX writeback) handshake, with a_waddr_i/a_wdata_i
//   b_valid_i/b_ready_o      requester B (LSU load writeback) handshake, with b_waddr_i/b_wdata_i
//   we_o/waddr_o/wdata_o     registered register-file write port
//   init_done_o              high once the register-file clear sequence has finished
//
// Build option: define IBEX_RF_CLEAR_ON_RESET_EN to zero registers 1..NUM_WORDS-1 after
// reset before arbitration starts; otherwise arbitration runs from reset release.
module ibex_rf_write_arbiter #(
  parameter bit          RV32E     = 1'b0,
  parameter int unsigned DataWidth = 32
) (
  input  logic                 clk_int,
  input  logic                 rst_ni,
  input  logic                 a_valid_i,
  output logic                 a_ready_o,
  input  logic [4:0]           a_waddr_i,
  input  logic [DataWidth-1:0] a_wdata_i,
  input  logic                 b_valid_i,
  output logic                 b_ready_o,
  input  logic [4:0]           b_waddr_i,
  input  logic [DataWidth-1:0] b_wdata_i,
  output logic                 we_o,
  output logic [4:0]           waddr_o,
  output logic [DataWidth-1:0] wdata_o,
  output logic                 init_done_o
);
  logic                 run;
  logic                 prio_a_q;
  logic                 a_gnt, b_gnt, xfer;
  logic [4:0]           raw_addr, sel_addr;
  logic [DataWidth-1:0] sel_data;
  logic                 we_q;
  logic [4:0]           waddr_q;
  logic [DataWidth-1:0] wdata_q;

`ifdef IBEX_RF_CLEAR_ON_RESET_EN
  typedef enum logic {Clear, Run} state_e;
  localparam logic [4:0] LastAddr = RV32E ? 5'd15 : 5'd31;
  state_e     state_q;
  logic [4:0] cnt_q;
  assign run = (state_q == Run);
`else
  assign run = 1'b1;
`endif

  // prio_a_q is set when A lost the most recent contention
  assign a_gnt    = run && a_valid_i && (!b_valid_i || prio_a_q);
  assign b_gnt    = run && b_valid_i && !a_gnt;
  assign xfer     = a_gnt || b_gnt;
  assign raw_addr = a_gnt ? a_waddr_i : b_waddr_i;
  // a 16-entry file has no bit 4, so it is dropped before the x0 check
  assign sel_addr = RV32E ? {1'b0, raw_addr[3:0]} : raw_addr;
  assign sel_data = a_gnt ? a_wdata_i : b_wdata_i;

  always_ff @(posedge clk_int or negedge rst_ni) begin
    if (!rst_ni) begin
      we_q     <= 1'b0;
      waddr_q  <= 5'd0;
      wdata_q  <= '0;
      prio_a_q <= 1'b0;
`ifdef IBEX_RF_CLEAR_ON_RESET_EN
      state_q  <= Clear;
      cnt_q    <= 5'd1;
`endif
    end else begin
      if (a_valid_i && b_valid_i && run) prio_a_q <= b_gnt;
`ifdef IBEX_RF_CLEAR_ON_RESET_EN
      if (state_q == Clear) begin
        we_q    <= 1'b1;
        waddr_q <= cnt_q;
        wdata_q <= '0;
        cnt_q   <= cnt_q + 5'd1;
        if (cnt_q == LastAddr) state_q <= Run;
      end else
`endif
      begin
        we_q <= xfer && (sel_addr != 5'd0);
        if (xfer) begin
          waddr_q <= sel_addr;
          wdata_q <= sel_data;
        end
      end
    end
  end

  assign a_ready_o   = a_gnt;
  assign b_ready_o   = b_gnt;
  assign we_o        = we_q;
  assign waddr_o     = waddr_q;
  assign wdata_o     = wdata_q;
  assign init_done_o = run;
endmodule

// File: tb/tb_ibex_rf_write_arbiter.sv
// tb_ibex_rf_write_arbiter: randomized self-checking bench for ibex_rf_write_arbiter (RV32E 0 and 1).
module tb_ibex_rf_write_arbiter;
  localparam int DW = 32;
  logic clk_int = 1'b0;
  logic rst_ni  = 1'b0;
  always #5 clk_int = ~clk_int;

  logic          a_valid_i = 1'b0, b_valid_i = 1'b0;
  logic [4:0]    a_waddr_i = '0, b_waddr_i = '0;
  logic [DW-1:0] a_wdata_i = '0, b_wdata_i = '0;
  logic          a_ready[2], b_ready[2], we[2], done[2];
  logic [4:0]    waddr[2];
  logic [DW-1:0] wdata[2];

  ibex_rf_write_arbiter #(.RV32E(1'b0), .DataWidth(DW)) dut (
    .clk_int(clk_int), .rst_ni(rst_ni),
    .a_valid_i(a_valid_i), .a_ready_o(a_ready[0]), .a_waddr_i(a_waddr_i), .a_wdata_i(a_wdata_i),
    .b_valid_i(b_valid_i), .b_ready_o(b_ready[0]), .b_waddr_i(b_waddr_i), .b_wdata_i(b_wdata_i),
    .we_o(we[0]), .waddr_o(waddr[0]), .wdata_o(wdata[0]), .init_done_o(done[0]));

  ibex_rf_write_arbiter #(.RV32E(1'b1), .DataWidth(DW)) dut_e (
    .clk_int(clk_int), .rst_ni(rst_ni),
    .a_valid_i(a_valid_i), .a_ready_o(a_ready[1]), .a_waddr_i(a_waddr_i), .a_wdata_i(a_wdata_i),
    .b_valid_i(b_valid_i), .b_ready_o(b_ready[1]), .b_waddr_i(b_waddr_i), .b_wdata_i(b_wdata_i),
    .we_o(we[1]), .waddr_o(waddr[1]), .wdata_o(wdata[1]), .init_done_o(done[1]));

  int n_vec = 0, n_err = 0;
  byte           last_loser;
  logic          m_we[2];
  logic [4:0]    m_addr[2];
  logic [DW-1:0] m_data[2];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [4:0] fold(input logic [4:0] a, input int e);
    return e ? {1'b0, a[3:0]} : a;
  endfunction

  task automatic check_out(input string tag);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("%s/we%0d", tag, i), we[i], m_we[i]);
      check($sformatf("%s/waddr%0d", tag, i), waddr[i], m_addr[i]);
      check($sformatf("%s/wdata%0d", tag, i), wdata[i], m_data[i]);
    end
  endtask

  // one arbitration cycle: drive at negedge, check readies, predict, check registered result
  task automatic step(input logic av, input logic [4:0] aa, input logic [DW-1:0] ad,
                      input logic bv, input logic [4:0] ba, input logic [DW-1:0] bd,
                      input string tag, output bit ga, output bit gb);
    logic [4:0] t;
    a_valid_i = av; a_waddr_i = aa; a_wdata_i = ad;
    b_valid_i = bv; b_waddr_i = ba; b_wdata_i = bd;
    #1;
    ga = av && (!bv || last_loser == "A");
    gb = bv && !ga;
    if (av && bv) last_loser = ga ? "B" : "A";
    for (int i = 0; i < 2; i++) begin
      check($sformatf("%s/a_rdy%0d", tag, i), a_ready[i], ga);
      check($sformatf("%s/b_rdy%0d", tag, i), b_ready[i], gb);
      check($sformatf("%s/done%0d", tag, i), done[i], 1'b1);
      t = fold(ga ? aa : ba, i);
      m_we[i] = (ga || gb) && t != 5'd0;
      if (ga || gb) begin
        m_addr[i] = t;
        m_data[i] = ga ? ad : bd;
      end
    end
    @(negedge clk_int);
    check_out(tag);
  endtask

  task automatic clear_seq(input int stop);
`ifdef IBEX_RF_CLEAR_ON_RESET_EN
    for (int k = 1; k <= stop; k++) begin
      @(negedge clk_int);
      check($sformatf("clr%0d/we", k), we[0], 1'b1);
      check($sformatf("clr%0d/waddr", k), waddr[0], k);
      check($sformatf("clr%0d/wdata", k), wdata[0], 0);
      check($sformatf("clr%0d/done", k), done[0], k == 31);
      check($sformatf("clr%0d/rdy", k), {a_ready[0], b_ready[0]}, 0);
      check($sformatf("clr%0d/we_e", k), we[1], k <= 15);
      check($sformatf("clr%0d/waddr_e", k), waddr[1], k <= 15 ? k : 15);
      check($sformatf("clr%0d/done_e", k), done[1], k >= 15);
    end
    m_addr[0] = 5'd31;
    m_addr[1] = 5'd15;
    m_we[0] = 1'b0;
    m_we[1] = 1'b0;
`endif
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    a_valid_i = 1'b0;
    b_valid_i = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      m_we[i] = 1'b0; m_addr[i] = '0; m_data[i] = '0;
      check($sformatf("rst/done%0d", i), done[i],
`ifdef IBEX_RF_CLEAR_ON_RESET_EN
            1'b0);
`else
            1'b1);
`endif
    end
    check_out("rst");
    last_loser = "B";
    repeat (2) @(negedge clk_int);
    rst_ni = 1'b1;
    clear_seq(31);
  endtask

  initial begin
    bit ga, gb, ha, hb;
    logic [4:0] aa, ba;
    logic [DW-1:0] ad, bd;
    @(negedge clk_int);
    do_reset();
`ifdef IBEX_RF_CLEAR_ON_RESET_EN
    do_reset();
    clear_seq(10);
    #2 rst_ni = 1'b0;
    #1 check("clr_abort/we", we[0], 1'b0);
    check("clr_abort/waddr", waddr[0], 0);
    @(negedge clk_int);
    do_reset();
`endif
    step(0, 0, 0, 0, 0, 0, "idle", ga, gb);
    step(1, 5, 32'hDEADBEEF, 0, 0, 0, "a_alone", ga, gb);
    for (int c = 0; c < 4; c++) begin
      step(1, 7, 32'h1000 + c, 1, 9, 32'h2000 + c, $sformatf("cont%0d", c), ga, gb);
      check($sformatf("cont%0d/winner_b", c), gb, (c % 2) == 0);
    end
    step(0, 0, 0, 1, 0, 32'h55, "b_x0", ga, gb);
    step(1, 5'h13, 32'hA5A5, 0, 0, 0, "a_13", ga, gb);
    step(0, 0, 0, 1, 5'h10, 32'h77, "b_10", ga, gb);
    ha = 0; hb = 0;
    aa = '0; ba = '0; ad = '0; bd = '0;
    for (int n = 0; n < 400; n++) begin
      if (!ha) begin
        aa = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
        ad = $urandom;
      end
      if (!hb) begin
        ba = ($urandom_range(0, 7) == 0) ? 5'd16 : 5'($urandom);
        bd = $urandom;
      end
      ha = ha || ($urandom_range(0, 9) < 6);
      hb = hb || ($urandom_range(0, 9) < 6);
      step(ha, aa, ad, hb, ba, bd, $sformatf("rnd%0d", n), ga, gb);
      ha = ha && !ga;
      hb = hb && !gb;
    end
    step(1, 1, 1, 1, 2, 2, "pre_rst", ga, gb);
    if (last_loser == "B") step(1, 1, 1, 1, 2, 2, "pre_rst2", ga, gb);
    a_valid_i = 1'b1; a_waddr_i = 5'd4; a_wdata_i = 32'hCAFE;
    b_valid_i = 1'b0;
    #2 rst_ni = 1'b0;
    #1 check("xfer_abort/we", we[0], 1'b0);
    check("xfer_abort/wdata", wdata[0], 0);
    @(negedge clk_int);
    do_reset();
    step(1, 3, 32'h33, 1, 6, 32'h66, "post_rst_prio", ga, gb);
    check("post_rst_prio/winner_b", gb, 1'b1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
